// File: rtl/arm7tdmi_lsu.sv
// arm7tdmi_lsu -- ARM-state load/store unit (LDR/STR/LDRB/STRB).
// Accepts one decoded memory op with its base and pre-shifted offset, forms
// the pre/post-indexed address and runs a single req/ack bus transaction.
// It then returns the load result for Rd and the written-back base for Rn.
// Ports:
//   clk, rst                  core clock, synchronous active-high reset
//   req_*                     decoded op in; req_ready high when IDLE
//   mem_req/we/addr/be/wdata  bus request, held until ack/err/timeout
//   mem_ack/err/rdata         bus response
//   rd_we/addr/data           one-cycle load result write
//   rn_we/addr/data           one-cycle base writeback
//   done, abort               one-cycle completion / data-abort pulses
module arm7tdmi_lsu #(
  parameter int BUS_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_load,
  input  logic        req_byte,
  input  logic        req_pre,
  input  logic        req_up,
  input  logic        req_writeback,
  input  logic [31:0] req_base,
  input  logic [31:0] req_offset,
  input  logic [31:0] req_store_data,
  input  logic [3:0]  req_rd,
  input  logic [3:0]  req_rn,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic        mem_err,
  input  logic [31:0] mem_rdata,
  output logic        rd_we,
  output logic [3:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic        rn_we,
  output logic [3:0]  rn_addr,
  output logic [31:0] rn_data,
  output logic        done,
  output logic        abort
);
  localparam int TW = $clog2(BUS_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(BUS_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state;

  // Captured op
  logic        op_load, op_byte, op_wb;
  logic [3:0]  op_rd, op_rn;
  logic [31:0] op_sum;
  logic [1:0]  op_lane;
  logic [TW-1:0] tmo_cnt;

  // Address arithmetic on the incoming op
  logic [31:0] sum, eff;
  always_comb begin
    sum = req_up ? req_base + req_offset : req_base - req_offset;
    eff = req_pre ? sum : req_base;
  end

  // Load data: word loads rotate right by the byte offset; byte loads take
  // the low lane of the same rotation, zero-extended.
  logic [63:0] rd_dbl;
  logic [31:0] rd_rot, load_val;
  always_comb begin
    rd_dbl   = {mem_rdata, mem_rdata} >> {op_lane, 3'b000};
    rd_rot   = rd_dbl[31:0];
    load_val = op_byte ? {24'h0, rd_rot[7:0]} : rd_rot;
  end

  assign req_ready = (state == IDLE) && !rst;

  logic timeout;
  assign timeout = (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      rd_we     <= 1'b0;
      rd_addr   <= '0;
      rd_data   <= '0;
      rn_we     <= 1'b0;
      rn_addr   <= '0;
      rn_data   <= '0;
      done      <= 1'b0;
      abort     <= 1'b0;
      op_load   <= 1'b0;
      op_byte   <= 1'b0;
      op_wb     <= 1'b0;
      op_rd     <= '0;
      op_rn     <= '0;
      op_sum    <= '0;
      op_lane   <= '0;
      tmo_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            state     <= ACCESS;
            op_load   <= req_load;
            op_byte   <= req_byte;
            op_wb     <= !req_pre || req_writeback;
            op_rd     <= req_rd;
            op_rn     <= req_rn;
            op_sum    <= sum;
            op_lane   <= eff[1:0];
            tmo_cnt   <= '0;
            mem_req   <= 1'b1;
            mem_we    <= !req_load;
            mem_addr  <= req_byte ? eff : {eff[31:2], 2'b00};
            mem_be    <= req_byte ? (4'b0001 << eff[1:0]) : 4'b1111;
            mem_wdata <= req_byte ? {4{req_store_data[7:0]}} : req_store_data;
          end
        end
        ACCESS: begin
          if (!timeout) tmo_cnt <= tmo_cnt + 1'b1;
          if (mem_err || mem_ack || timeout) begin
            state   <= RESP;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            done    <= 1'b1;
            rd_addr <= op_rd;
            rn_addr <= op_rn;
            rn_data <= op_sum;
            // Error wins over a simultaneous ack; timeout only without ack.
            if (mem_err || !mem_ack) begin
              abort <= 1'b1;
            end else begin
              rd_we   <= op_load;
              rd_data <= load_val;
              // Loaded value owns the register when Rd == Rn.
              rn_we   <= op_wb && !(op_load && op_rd == op_rn);
            end
          end
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          abort <= 1'b0;
          rd_we <= 1'b0;
          rn_we <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_arm7tdmi_lsu.sv
module tb_arm7tdmi_lsu;
  logic        clk = 0, rst = 1;
  logic        req_valid = 0, req_ready, req_load = 0, req_byte = 0, req_pre = 0;
  logic        req_up = 0, req_writeback = 0;
  logic [31:0] req_base = 0, req_offset = 0, req_store_data = 0;
  logic [3:0]  req_rd = 0, req_rn = 0;
  logic        mem_req, mem_we, mem_ack = 0, mem_err = 0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = 0;
  logic [3:0]  mem_be;
  logic        rd_we, rn_we, done, abort;
  logic [3:0]  rd_addr, rn_addr;
  logic [31:0] rd_data, rn_data;

  int n_cmp = 0, n_bad = 0;

  arm7tdmi_lsu #(.BUS_TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_load(req_load), .req_byte(req_byte), .req_pre(req_pre), .req_up(req_up),
    .req_writeback(req_writeback), .req_base(req_base), .req_offset(req_offset),
    .req_store_data(req_store_data), .req_rd(req_rd), .req_rn(req_rn),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_err(mem_err), .mem_rdata(mem_rdata),
    .rd_we(rd_we), .rd_addr(rd_addr), .rd_data(rd_data),
    .rn_we(rn_we), .rn_addr(rn_addr), .rn_data(rn_data),
    .done(done), .abort(abort)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        load, bt, pre, up, wb, err;
    logic [31:0] base, off, sd, rdata;
    logic [3:0]  rd, rn;
    int          dly;
    logic [31:0] e_addr, e_wdata, e_rdd, e_rnd;
    logic [3:0]  e_be;
    logic        e_we, e_rdwe, e_rnwe, e_abort;
  } vec_t;

  vec_t v[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic run_vec(input vec_t t);
    req_valid = 1; req_load = t.load; req_byte = t.bt; req_pre = t.pre; req_up = t.up;
    req_writeback = t.wb; req_base = t.base; req_offset = t.off; req_store_data = t.sd;
    req_rd = t.rd; req_rn = t.rn;
    chk({t.name, " ready"}, {31'b0, req_ready}, 1);
    tick;
    req_valid = 0;
    chk({t.name, " mem_req"}, {31'b0, mem_req}, 1);
    chk({t.name, " addr"}, mem_addr, t.e_addr);
    chk({t.name, " be"}, {28'b0, mem_be}, {28'b0, t.e_be});
    chk({t.name, " we"}, {31'b0, mem_we}, {31'b0, t.e_we});
    if (t.e_we) chk({t.name, " wdata"}, mem_wdata, t.e_wdata);
    for (int i = 0; i < t.dly; i++) tick;
    chk({t.name, " held addr"}, mem_addr, t.e_addr);
    mem_ack = 1; mem_err = t.err; mem_rdata = t.rdata;
    tick;
    mem_ack = 0; mem_err = 0; mem_rdata = 32'h0;
    chk({t.name, " done"}, {31'b0, done}, 1);
    chk({t.name, " abort"}, {31'b0, abort}, {31'b0, t.e_abort});
    chk({t.name, " mem_req low"}, {31'b0, mem_req}, 0);
    chk({t.name, " rd_we"}, {31'b0, rd_we}, {31'b0, t.e_rdwe});
    chk({t.name, " rn_we"}, {31'b0, rn_we}, {31'b0, t.e_rnwe});
    if (t.e_rdwe) begin
      chk({t.name, " rd_data"}, rd_data, t.e_rdd);
      chk({t.name, " rd_addr"}, {28'b0, rd_addr}, {28'b0, t.rd});
    end
    if (t.e_rnwe) begin
      chk({t.name, " rn_data"}, rn_data, t.e_rnd);
      chk({t.name, " rn_addr"}, {28'b0, rn_addr}, {28'b0, t.rn});
    end
    tick;
    chk({t.name, " done pulse"}, {31'b0, done}, 0);
    chk({t.name, " ready again"}, {31'b0, req_ready}, 1);
  endtask

  initial begin
    //      name     ld bt pr up wb er base          off           sd            rdata         rd    rn    dly addr          wdata         rdd           rnd           be     we rdwe rnwe abort
    v[0] = '{"ldr",  1, 0, 1, 1, 0, 0, 32'h10000000, 32'h8,        32'h0,        32'hDEADBEEF, 4'd1, 4'd2, 2, 32'h10000008, 32'h0,        32'hDEADBEEF, 32'h0,        4'hF, 0, 1, 0, 0};
    v[1] = '{"rot",  1, 0, 1, 1, 0, 0, 32'h10000001, 32'h0,        32'h0,        32'h11223344, 4'd1, 4'd2, 1, 32'h10000000, 32'h0,        32'h44112233, 32'h0,        4'hF, 0, 1, 0, 0};
    v[2] = '{"strb", 0, 1, 0, 0, 0, 0, 32'h10000003, 32'h4,        32'h000000AB, 32'h0,        4'd3, 4'd4, 1, 32'h10000003, 32'hABABABAB, 32'h0,        32'h0FFFFFFF, 4'h8, 1, 0, 1, 0};
    v[3] = '{"wrap", 1, 0, 1, 1, 1, 0, 32'hFFFFFFFC, 32'h8,        32'h0,        32'h12345678, 4'd5, 4'd6, 1, 32'h00000004, 32'h0,        32'h12345678, 32'h00000004, 4'hF, 0, 1, 1, 0};
    v[4] = '{"rdrn", 1, 0, 1, 1, 1, 0, 32'hFFFFFFFC, 32'h8,        32'h0,        32'h12345678, 4'd7, 4'd7, 1, 32'h00000004, 32'h0,        32'h12345678, 32'h0,        4'hF, 0, 1, 0, 0};
    v[5] = '{"ldrb", 1, 1, 1, 1, 0, 0, 32'h10000002, 32'h0,        32'h0,        32'hAABBCCDD, 4'd8, 4'd9, 0, 32'h10000002, 32'h0,        32'h000000BB, 32'h0,        4'h4, 0, 1, 0, 0};
    v[6] = '{"err",  1, 0, 1, 1, 1, 1, 32'h20000000, 32'h4,        32'h0,        32'h55555555, 4'd1, 4'd3, 1, 32'h20000004, 32'h0,        32'h0,        32'h0,        4'hF, 0, 0, 0, 1};
    v[7] = '{"str",  0, 0, 1, 1, 1, 0, 32'h00000100, 32'h10,       32'hCAFEF00D, 32'h0,        4'd2, 4'd10,0, 32'h00000110, 32'hCAFEF00D, 32'h0,        32'h00000110, 4'hF, 1, 0, 1, 0};

    // Reset state
    tick;
    chk("rst ready", {31'b0, req_ready}, 0);
    chk("rst mem_req", {31'b0, mem_req}, 0);
    chk("rst outputs", {mem_addr | mem_wdata | rd_data | rn_data}, 0);
    chk("rst strobes", {25'b0, mem_we, rd_we, rn_we, done, abort, |mem_be, |rd_addr}, 0);
    tick;
    rst = 0;
    tick;

    for (int i = 0; i < 8; i++) run_vec(v[i]);

    // Timeout: no ack, mem_req stays up for exactly 64 cycles
    begin
      int n = 0;
      req_valid = 1; req_load = 1; req_byte = 0; req_pre = 1; req_up = 1; req_writeback = 1;
      req_base = 32'h30000000; req_offset = 0; req_rd = 1; req_rn = 2;
      tick;
      req_valid = 0;
      while (mem_req && n < 200) begin n++; tick; end
      chk("tmo cycles", n, 64);
      chk("tmo done", {31'b0, done}, 1);
      chk("tmo abort", {31'b0, abort}, 1);
      chk("tmo no writes", {30'b0, rd_we, rn_we}, 0);
      tick;
      chk("tmo ready", {31'b0, req_ready}, 1);
    end

    // Reset mid-access
    begin
      int seen = 0;
      req_valid = 1; req_load = 0; req_byte = 0; req_pre = 1; req_base = 32'h40;
      tick;
      req_valid = 0;
      chk("mid mem_req", {31'b0, mem_req}, 1);
      tick;
      rst = 1;
      tick;
      chk("mid drop", {31'b0, mem_req}, 0);
      chk("mid ready in rst", {31'b0, req_ready}, 0);
      chk("mid no strobes", {29'b0, done, rd_we, rn_we}, 0);
      rst = 0;
      #1;
      chk("mid ready after", {31'b0, req_ready}, 1);
      for (int i = 0; i < 4; i++) begin
        tick;
        if (done || rd_we || rn_we || mem_req) seen++;
      end
      chk("mid quiet", seen, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
